// File: rtl/axis_fifo_pkt.sv
// Single-clock AXI-Stream FIFO with tlast side-band and fill level.
// Define AXIS_FIFO_PKT_MODE_EN to hold output until a whole packet is stored.
module axis_fifo_pkt #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [LVL_W-1:0]      level
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wp, rp;
  logic                push, pop;

  assign s_axis_tready = (level != LVL_W'(DEPTH));
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;
  // First-word fall-through: head entry is always presented.
  assign {m_axis_tlast, m_axis_tdata} = mem[rp];

  // Storage is not reset; only pointers and level define validity.
  always_ff @(posedge aclk) begin
    if (push) mem[wp] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [LVL_W-1:0] pkt_cnt;
  logic             out_hold;
  logic             push_last, pop_last;

  assign push_last = push && s_axis_tlast;
  assign pop_last  = pop && m_axis_tlast;
  // A full FIFO with no complete packet streams cut-through so long packets
  // cannot deadlock; out_hold keeps an offered beat valid until it is taken.
  assign m_axis_tvalid = out_hold ||
                         ((level != '0) && ((pkt_cnt != '0) || !s_axis_tready));

  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_cnt  <= '0;
      out_hold <= 1'b0;
    end else begin
      out_hold <= m_axis_tvalid && !m_axis_tready;
      if (push_last && !pop_last)      pkt_cnt <= pkt_cnt + 1'b1;
      else if (pop_last && !push_last) pkt_cnt <= pkt_cnt - 1'b1;
    end
  end
`else
  assign m_axis_tvalid = (level != '0);
`endif

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Self-checking bench for axis_fifo_pkt: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random back-pressure.
module tb_axis_fifo_pkt;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_tdata, m_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic          m_tvalid, m_tlast, m_tready;
  logic [LW-1:0] level;

  axis_fifo_pkt #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .level(level)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {tlast,data}; hold = beat offered last cycle not taken.
  logic [DW:0]   q[$];
  logic [DW-1:0] dut_out[$];
  bit            hold = 0;
  bit            model_ok = 0;
  int            n_push = 0;

  function automatic bit exp_valid();
    int npkts = 0;
    foreach (q[i]) if (q[i][DW]) npkts++;
`ifdef AXIS_FIFO_PKT_MODE_EN
    return hold || (q.size() != 0 && (npkts > 0 || q.size() == DEPTH));
`else
    return q.size() != 0;
`endif
  endfunction

  always @(posedge aclk) begin
    if (!areset && m_tvalid && m_tready) dut_out.push_back(m_tdata);
    if (areset) begin
      q.delete();
      hold = 0;
      model_ok = 1;
    end else if (model_ok) begin
      bit v, r;
      v = exp_valid();
      r = (q.size() != DEPTH);
      hold = v && !m_tready;
      if (v && m_tready) void'(q.pop_front());
      if (s_tvalid && r) begin
        q.push_back({s_tlast, s_tdata});
        n_push++;
      end
    end
  end

  always @(negedge aclk) begin
    if (model_ok && !areset) begin
      bit v;
      v = exp_valid();
      chk("level", 32'(level), 32'(q.size()));
      chk("s_tready", 32'(s_tready), 32'(q.size() != DEPTH));
      chk("m_tvalid", 32'(m_tvalid), 32'(v));
      if (v) begin
        chk("m_tdata", 32'(m_tdata), 32'(q[0][DW-1:0]));
        chk("m_tlast", 32'(m_tlast), 32'(q[0][DW]));
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l);
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    step();
    s_tvalid = 1'b0;
  endtask

  initial begin
    int cyc;
    int bad;
    bit seen;
    areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    step(); step();
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_level", 32'(level), 0);
    chk("rst_tready", 32'(s_tready), 1);
    chk("rst_tvalid", 32'(m_tvalid), 0);

    // three beats buffered then released
    step();
    push_beat(8'h11, 1'b1); push_beat(8'h22, 1'b1); push_beat(8'h33, 1'b1);
    @(negedge aclk);
    chk("t1_level", 32'(level), 3);
    chk("t1_tready", 32'(s_tready), 1);
    #1; dut_out.delete(); m_tready = 1'b1;
    step(); step(); step();
    m_tready = 1'b0;
    @(negedge aclk);
    chk("t1_level_end", 32'(level), 0);
    chk("t1_count", 32'(dut_out.size()), 3);
    if (dut_out.size() == 3) begin
      chk("t1_d0", 32'(dut_out[0]), 32'h11);
      chk("t1_d1", 32'(dut_out[1]), 32'h22);
      chk("t1_d2", 32'(dut_out[2]), 32'h33);
    end

    // fill, one pop, refill across pointer wrap
    #1;
    for (int i = 0; i < DEPTH; i++) push_beat(DW'(i), 1'b1);
    @(negedge aclk);
    chk("t2_full_level", 32'(level), 16);
    chk("t2_full_tready", 32'(s_tready), 0);
    #1; dut_out.delete(); m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    @(negedge aclk);
    chk("t2_tready_after_pop", 32'(s_tready), 1);
    #1;
    push_beat(8'h10, 1'b1);
    m_tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    m_tready = 1'b0;
    chk("t2_count", 32'(dut_out.size()), 17);
    bad = 0;
    foreach (dut_out[i]) if (dut_out[i] != DW'(i)) bad++;
    chk("t2_order", 32'(bad), 0);

    // continuous streaming
    dut_out.delete();
    s_tvalid = 1'b1; s_tlast = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_tdata = DW'(i);
      step();
      if (i > 0) begin
        @(negedge aclk);
        chk("t3_level", 32'(level), 1);
        #1;
      end
    end
    s_tvalid = 1'b0;
    step();
    m_tready = 1'b0;
    chk("t3_count", 32'(dut_out.size()), 100);
    bad = 0;
    foreach (dut_out[i]) if (dut_out[i] != DW'(i)) bad++;
    chk("t3_order", 32'(bad), 0);

    // reset mid-stream
    for (int i = 0; i < 5; i++) push_beat(DW'(8'h50 + i), 1'b1);
    @(negedge aclk);
    chk("t4_level5", 32'(level), 5);
    #1; areset = 1'b1;
    step();
    areset = 1'b0;
    @(negedge aclk);
    chk("t4_level", 32'(level), 0);
    chk("t4_tvalid", 32'(m_tvalid), 0);
    chk("t4_tready", 32'(s_tready), 1);
    #1;
    push_beat(8'hA5, 1'b1);
    dut_out.delete(); m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    chk("t4_count", 32'(dut_out.size()), 1);
    if (dut_out.size() == 1) chk("t4_first", 32'(dut_out[0]), 32'hA5);

`ifdef AXIS_FIFO_PKT_MODE_EN
    // three-beat packet held until tlast stored
    m_tready = 1'b1; dut_out.delete();
    push_beat(8'h01, 1'b0);
    @(negedge aclk); chk("p1_v1", 32'(m_tvalid), 0); #1;
    push_beat(8'h02, 1'b0);
    @(negedge aclk); chk("p1_v2", 32'(m_tvalid), 0); #1;
    push_beat(8'h03, 1'b1);
    @(negedge aclk); chk("p1_v3", 32'(m_tvalid), 1); #1;
    step(); step(); step();
    chk("p1_count", 32'(dut_out.size()), 3);

    // 20-beat packet escapes via full condition
    dut_out.delete(); n_push = 0; seen = 0; cyc = 0;
    s_tvalid = 1'b1; s_tdata = 8'h00; s_tlast = 1'b0;
    while (n_push < 20 && cyc < 300) begin
      step(); cyc++;
      s_tdata = DW'(n_push); s_tlast = (n_push == 19);
      if (level == LW'(DEPTH) && !seen) begin
        seen = 1;
        chk("p2_no_early_pop", 32'(dut_out.size()), 0);
      end
    end
    s_tvalid = 1'b0;
    chk("p2_pushed", 32'(n_push), 20);
    chk("p2_reached_full", 32'(seen), 1);
    cyc = 0;
    while (dut_out.size() < 20 && cyc < 100) begin step(); cyc++; end
    chk("p2_count", 32'(dut_out.size()), 20);
    bad = 0;
    foreach (dut_out[i]) if (dut_out[i] != DW'(i)) bad++;
    chk("p2_order", 32'(bad), 0);
    m_tready = 1'b0;
`endif

    // random back-pressure on both sides
    dut_out.delete(); n_push = 0; cyc = 0;
    while (n_push < 1000 && cyc < 20000) begin
      s_tvalid = ($urandom_range(0, 2) != 0);
      s_tdata  = DW'($urandom);
      s_tlast  = ($urandom_range(0, 3) == 0);
      m_tready = ($urandom_range(0, 2) != 0);
      step(); cyc++;
    end
    chk("rnd_pushed", 32'(n_push), 1000);
    // terminating beat so any partial packet can drain
    s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 8'hEE; m_tready = 1'b1;
    cyc = n_push;
    while (n_push == cyc && n_push < 1001) step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    cyc = 0;
    while (q.size() != 0 && cyc < 200) begin step(); cyc++; end
    chk("rnd_drained", 32'(level), 0);
    chk("rnd_out_count", 32'(dut_out.size()), 32'(n_push));
    m_tready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
